// File: rtl/reg_scoreboard.sv
// Register-write scoreboard: tracks in-flight destination registers and
// not-yet-forwardable results, and stalls ID. Define SB_MDU_EN for MDU tracking.
module reg_scoreboard #(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_issue_i,
  input  logic       id_reg_we_i,
  input  logic [4:0] id_reg_waddr_i,
  input  logic       id_is_load_i,
  input  logic       id_is_mdu_i,
  input  logic [4:0] id_reg1_raddr_i,
  input  logic [4:0] id_reg2_raddr_i,
  input  logic       cu_reg1_RE_i,
  input  logic       cu_reg2_RE_i,
  input  logic       wb_reg_we_i,
  input  logic [4:0] wb_reg_waddr_i,
  input  logic       mdu_done_i,
  input  logic       flush_i,
  output logic       sb_busy1_o,
  output logic       sb_busy2_o,
  output logic       sb_stall_o,
  output logic       sb_err_o
);

  logic [31:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]            nr_q, nr_d;
  logic [4:0]             ld_addr_q, ld_addr_d;
  logic [1:0]             ld_timer_q, ld_timer_d;
  logic                   err_q, err_d;

  logic issue_wr, wb_wr, is_mdu, mdu_block, mdu_clear;
  logic src1_nr, src2_nr, cnt_full, load_block, accept, same_reg;

`ifdef SB_MDU_EN
  logic       mdu_busy_q, mdu_busy_d;
  logic [4:0] mdu_addr_q, mdu_addr_d;

  assign is_mdu    = id_is_mdu_i & ~id_is_load_i;
  assign mdu_block = is_mdu & mdu_busy_q & ~mdu_done_i;
  assign mdu_clear = mdu_busy_q & mdu_done_i;
`else
  logic unused_mdu;

  assign unused_mdu = id_is_mdu_i | mdu_done_i;
  assign is_mdu     = 1'b0;
  assign mdu_block  = 1'b0;
  assign mdu_clear  = 1'b0;
`endif

  assign issue_wr = id_issue_i & id_reg_we_i & (id_reg_waddr_i != '0);
  assign wb_wr    = wb_reg_we_i & (wb_reg_waddr_i != '0);
  assign same_reg = wb_wr & (wb_reg_waddr_i == id_reg_waddr_i);

  assign src1_nr    = cu_reg1_RE_i & (id_reg1_raddr_i != '0) & nr_q[id_reg1_raddr_i];
  assign src2_nr    = cu_reg2_RE_i & (id_reg2_raddr_i != '0) & nr_q[id_reg2_raddr_i];
  assign cnt_full   = (cnt_q[id_reg_waddr_i] == '1) & ~same_reg;
  assign load_block = id_is_load_i & (ld_timer_q != '0);

  // Stall depends only on state and raw inputs, never on the accepted issue.
  assign sb_stall_o = src1_nr | src2_nr | (issue_wr & (cnt_full | load_block | mdu_block));
  assign accept     = issue_wr & ~sb_stall_o;

  assign sb_busy1_o = cu_reg1_RE_i & (id_reg1_raddr_i != '0) & (cnt_q[id_reg1_raddr_i] != '0);
  assign sb_busy2_o = cu_reg2_RE_i & (id_reg2_raddr_i != '0) & (cnt_q[id_reg2_raddr_i] != '0);
  assign sb_err_o   = err_q;

  always_comb begin
    cnt_d      = cnt_q;
    nr_d       = nr_q;
    ld_addr_d  = ld_addr_q;
    ld_timer_d = ld_timer_q;
    err_d      = err_q;
`ifdef SB_MDU_EN
    mdu_busy_d = mdu_busy_q;
    mdu_addr_d = mdu_addr_q;
`endif
    if (flush_i) begin
      cnt_d      = '0;
      nr_d       = '0;
      ld_timer_d = '0;
`ifdef SB_MDU_EN
      mdu_busy_d = 1'b0;
`endif
    end else begin
      // Releases first so that a same-cycle issue to that register wins.
      if (ld_timer_q != '0) begin
        ld_timer_d = ld_timer_q - 2'd1;
        if (ld_timer_q == 2'd1) nr_d[ld_addr_q] = 1'b0;
      end
`ifdef SB_MDU_EN
      if (mdu_clear) begin
        nr_d[mdu_addr_q] = 1'b0;
        mdu_busy_d       = 1'b0;
      end
`endif
      if (accept) begin
        if (id_is_load_i) begin
          nr_d[id_reg_waddr_i] = 1'b1;
          ld_timer_d           = 2'(LOAD_LAT);
          ld_addr_d            = id_reg_waddr_i;
        end else if (is_mdu) begin
          nr_d[id_reg_waddr_i] = 1'b1;
`ifdef SB_MDU_EN
          mdu_busy_d           = 1'b1;
          mdu_addr_d           = id_reg_waddr_i;
`endif
        end else begin
          nr_d[id_reg_waddr_i] = 1'b0;
        end
      end
      if (wb_wr && (cnt_q[wb_reg_waddr_i] == '0)) err_d = 1'b1;
      if (!(accept && same_reg)) begin
        if (accept)
          cnt_d[id_reg_waddr_i] = cnt_q[id_reg_waddr_i] + CNT_W'(1);
        if (wb_wr && (cnt_q[wb_reg_waddr_i] != '0))
          cnt_d[wb_reg_waddr_i] = cnt_q[wb_reg_waddr_i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      nr_q       <= '0;
      ld_addr_q  <= '0;
      ld_timer_q <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      nr_q       <= nr_d;
      ld_addr_q  <= ld_addr_d;
      ld_timer_q <= ld_timer_d;
      err_q      <= err_d;
    end
  end

`ifdef SB_MDU_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdu_busy_q <= 1'b0;
      mdu_addr_q <= '0;
    end else begin
      mdu_busy_q <= mdu_busy_d;
      mdu_addr_q <= mdu_addr_d;
    end
  end
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: constant vector table, hand sequences and a
// randomized run against a behavioural model of the dependency rules.
module tb_reg_scoreboard;
  localparam int LAT  = 1;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
`ifdef SB_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_issue_i, id_reg_we_i, id_is_load_i, id_is_mdu_i;
  logic [4:0] id_reg_waddr_i, id_reg1_raddr_i, id_reg2_raddr_i, wb_reg_waddr_i;
  logic       cu_reg1_RE_i, cu_reg2_RE_i, wb_reg_we_i, mdu_done_i, flush_i;
  logic       sb_busy1_o, sb_busy2_o, sb_stall_o, sb_err_o;

  reg_scoreboard #(.LOAD_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_issue_i(id_issue_i), .id_reg_we_i(id_reg_we_i), .id_reg_waddr_i(id_reg_waddr_i),
    .id_is_load_i(id_is_load_i), .id_is_mdu_i(id_is_mdu_i),
    .id_reg1_raddr_i(id_reg1_raddr_i), .id_reg2_raddr_i(id_reg2_raddr_i),
    .cu_reg1_RE_i(cu_reg1_RE_i), .cu_reg2_RE_i(cu_reg2_RE_i),
    .wb_reg_we_i(wb_reg_we_i), .wb_reg_waddr_i(wb_reg_waddr_i),
    .mdu_done_i(mdu_done_i), .flush_i(flush_i),
    .sb_busy1_o(sb_busy1_o), .sb_busy2_o(sb_busy2_o),
    .sb_stall_o(sb_stall_o), .sb_err_o(sb_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit iss, we, ld, mdu, re1, re2, wbwe, done, fl;
    bit [4:0] rd, r1, r2, wba;
    bit b1, b2, st, er;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int m_cnt [32];
  bit m_nr  [32];
  int m_tmr, m_ld, m_maddr;
  bit m_mbusy, m_err;

  task automatic chk(input string nm, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0b exp=%0b t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin m_cnt[i] = 0; m_nr[i] = 0; end
    m_tmr = 0; m_ld = 0; m_maddr = 0; m_mbusy = 0; m_err = 0;
  endfunction

  function automatic bit m_busy(input logic re, input logic [4:0] a);
    return re && (a != 0) && (m_cnt[int'(a)] != 0);
  endfunction

  function automatic bit m_stall();
    int rd, r1, r2, wa;
    bit s;
    rd = int'(id_reg_waddr_i); r1 = int'(id_reg1_raddr_i);
    r2 = int'(id_reg2_raddr_i); wa = int'(wb_reg_waddr_i);
    s = (cu_reg1_RE_i && r1 != 0 && m_nr[r1]) || (cu_reg2_RE_i && r2 != 0 && m_nr[r2]);
    if (id_issue_i && id_reg_we_i && rd != 0) begin
      if (m_cnt[rd] == CMAX && !(wb_reg_we_i && wa == rd)) s = 1;
      if (id_is_load_i && m_tmr != 0) s = 1;
      if (MDU_EN && !id_is_load_i && id_is_mdu_i && m_mbusy && !mdu_done_i) s = 1;
    end
    return s;
  endfunction

  function automatic void model_step();
    int rd, wa;
    bit acc, wbv;
    rd  = int'(id_reg_waddr_i);
    wa  = int'(wb_reg_waddr_i);
    acc = id_issue_i && id_reg_we_i && rd != 0 && !m_stall();
    wbv = wb_reg_we_i && wa != 0;
    if (flush_i) begin
      for (int i = 0; i < 32; i++) begin m_cnt[i] = 0; m_nr[i] = 0; end
      m_tmr = 0; m_mbusy = 0;
      return;
    end
    if (m_tmr != 0) begin
      m_tmr--;
      if (m_tmr == 0) m_nr[m_ld] = 0;
    end
    if (MDU_EN && m_mbusy && mdu_done_i) begin m_nr[m_maddr] = 0; m_mbusy = 0; end
    if (acc) begin
      if (id_is_load_i) begin m_nr[rd] = 1; m_tmr = LAT; m_ld = rd; end
      else if (MDU_EN && id_is_mdu_i) begin m_nr[rd] = 1; m_mbusy = 1; m_maddr = rd; end
      else m_nr[rd] = 0;
    end
    if (wbv && m_cnt[wa] == 0) m_err = 1;
    if (!(acc && wbv && rd == wa)) begin
      if (acc) m_cnt[rd]++;
      if (wbv && m_cnt[wa] > 0) m_cnt[wa]--;
    end
  endfunction

  function automatic vec_t mk(input int iss, we, rd, ld, r1, re1, r2, re2,
                              wbwe, wba, fl, b1, b2, st, er);
    vec_t v;
    v.iss = iss[0]; v.we = we[0]; v.rd = 5'(rd); v.ld = ld[0]; v.mdu = 0; v.done = 0;
    v.r1 = 5'(r1); v.re1 = re1[0]; v.r2 = 5'(r2); v.re2 = re2[0];
    v.wbwe = wbwe[0]; v.wba = 5'(wba); v.fl = fl[0];
    v.b1 = b1[0]; v.b2 = b2[0]; v.st = st[0]; v.er = er[0];
    return v;
  endfunction

  task automatic set_in(input vec_t v);
    id_issue_i = v.iss; id_reg_we_i = v.we; id_reg_waddr_i = v.rd;
    id_is_load_i = v.ld; id_is_mdu_i = v.mdu;
    id_reg1_raddr_i = v.r1; cu_reg1_RE_i = v.re1;
    id_reg2_raddr_i = v.r2; cu_reg2_RE_i = v.re2;
    wb_reg_we_i = v.wbwe; wb_reg_waddr_i = v.wba;
    mdu_done_i = v.done; flush_i = v.fl;
  endtask

  // Called at posedge+1; checks mid-cycle, then advances one clock.
  task automatic run_cycle(input vec_t v, input bit use_tab, input string nm);
    set_in(v);
    #3;
    if (use_tab) begin
      chk({nm, "_busy1"}, sb_busy1_o, v.b1);
      chk({nm, "_busy2"}, sb_busy2_o, v.b2);
      chk({nm, "_stall"}, sb_stall_o, v.st);
      chk({nm, "_err"},   sb_err_o,   v.er);
    end else begin
      chk({nm, "_busy1"}, sb_busy1_o, m_busy(cu_reg1_RE_i, id_reg1_raddr_i));
      chk({nm, "_busy2"}, sb_busy2_o, m_busy(cu_reg2_RE_i, id_reg2_raddr_i));
      chk({nm, "_stall"}, sb_stall_o, m_stall());
      chk({nm, "_err"},   sb_err_o,   m_err);
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic vec_t rnd();
    vec_t v;
    v = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    v.iss  = ($urandom_range(0, 9) < 7);
    v.we   = ($urandom_range(0, 9) < 8);
    v.rd   = 5'($urandom_range(0, 7));
    v.ld   = ($urandom_range(0, 3) == 0);
    v.mdu  = ($urandom_range(0, 5) == 0);
    v.r1   = 5'($urandom_range(0, 7));
    v.re1  = $urandom_range(0, 1) == 1;
    v.r2   = 5'($urandom_range(0, 7));
    v.re2  = $urandom_range(0, 1) == 1;
    v.wbwe = ($urandom_range(0, 9) < 4);
    v.wba  = 5'($urandom_range(0, 7));
    v.done = ($urandom_range(0, 2) == 0);
    v.fl   = ($urandom_range(0, 49) == 0);
    return v;
  endfunction

  vec_t tab [23];
  vec_t hv;

  initial begin
    //          iss we rd ld  r1 re1 r2 re2 wbwe wba fl  b1 b2 st er
    tab[0]  = mk(0, 0, 0, 0,  5, 1,  0, 0,  0,  0, 0,  0, 0, 0, 0);
    tab[1]  = mk(1, 1, 5, 0,  0, 0,  0, 0,  0,  0, 0,  0, 0, 0, 0);
    tab[2]  = mk(0, 0, 0, 0,  5, 1,  0, 0,  0,  0, 0,  1, 0, 0, 0);
    tab[3]  = mk(0, 0, 0, 0,  5, 1,  0, 0,  1,  5, 0,  1, 0, 0, 0);
    tab[4]  = mk(0, 0, 0, 0,  5, 1,  0, 0,  0,  0, 0,  0, 0, 0, 0);
    tab[5]  = mk(1, 1, 6, 1,  0, 0,  0, 0,  0,  0, 0,  0, 0, 0, 0);
    tab[6]  = mk(1, 1,10, 0,  6, 1,  0, 0,  0,  0, 0,  1, 0, 1, 0);
    tab[7]  = mk(1, 1,10, 0,  6, 1,  0, 0,  0,  0, 0,  1, 0, 0, 0);
    tab[8]  = mk(1, 1, 7, 0, 10, 1,  0, 0,  1,  6, 0,  1, 0, 0, 0);
    tab[9]  = mk(1, 1, 7, 0,  0, 0,  6, 1,  0,  0, 0,  0, 0, 0, 0);
    tab[10] = mk(1, 1, 7, 0,  7, 1,  0, 0,  0,  0, 0,  1, 0, 0, 0);
    tab[11] = mk(1, 1, 7, 0,  7, 1,  0, 0,  0,  0, 0,  1, 0, 1, 0);
    tab[12] = mk(1, 1, 7, 0,  7, 1,  0, 0,  1,  7, 0,  1, 0, 0, 0);
    tab[13] = mk(1, 1, 7, 0,  7, 1,  0, 0,  0,  0, 0,  1, 0, 1, 0);
    tab[14] = mk(0, 0, 0, 0,  0, 1,  0, 0,  1,  9, 0,  0, 0, 0, 0);
    tab[15] = mk(0, 0, 0, 0,  0, 0,  0, 0,  0,  0, 0,  0, 0, 0, 1);
    tab[16] = mk(1, 1, 0, 0,  0, 1,  0, 1,  0,  0, 0,  0, 0, 0, 1);
    tab[17] = mk(1, 1, 0, 1,  0, 1,  0, 0,  0,  0, 0,  0, 0, 0, 1);
    tab[18] = mk(1, 1,12, 1,  0, 0,  0, 0,  0,  0, 0,  0, 0, 0, 1);
    tab[19] = mk(1, 1, 5, 0,  0, 0,  0, 0,  0,  0, 0,  0, 0, 0, 1);
    tab[20] = mk(1, 1,11, 1,  0, 0,  0, 0,  0,  0, 0,  0, 0, 0, 1);
    tab[21] = mk(0, 0, 0, 0, 11, 1,  5, 1,  0,  0, 1,  1, 1, 1, 1);
    tab[22] = mk(0, 0, 0, 0, 11, 1,  7, 1,  0,  0, 0,  0, 0, 0, 1);

    // Outputs during reset must be quiet whatever the inputs.
    set_in(mk(1, 1, 3, 1, 3, 1, 4, 1, 1, 3, 0, 0, 0, 0, 0));
    #2;
    chk("rst_busy1", sb_busy1_o, 1'b0);
    chk("rst_busy2", sb_busy2_o, 1'b0);
    chk("rst_stall", sb_stall_o, 1'b0);
    chk("rst_err",   sb_err_o,   1'b0);
    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 23; i++) run_cycle(tab[i], 1'b1, $sformatf("tab%0d", i));

`ifdef SB_MDU_EN
    do_reset();
    hv = mk(1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); hv.mdu = 1;
    run_cycle(hv, 1'b1, "mdu_issue");
    hv = mk(0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    run_cycle(hv, 1'b1, "mdu_dep");
    hv = mk(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); hv.mdu = 1;
    run_cycle(hv, 1'b1, "mdu_second");
    hv = mk(0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0); hv.done = 1;
    run_cycle(hv, 1'b1, "mdu_done");
    hv = mk(1, 1, 9, 0, 8, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0); hv.mdu = 1;
    run_cycle(hv, 1'b1, "mdu_after");
`endif

    do_reset();
    for (int i = 0; i < 400; i++) run_cycle(rnd(), 1'b0, $sformatf("rnd%0d", i));

    // Asynchronous reset in the middle of in-flight work.
    do_reset();
    run_cycle(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, "mid_a");
    hv = mk(1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); hv.mdu = 1;
    run_cycle(hv, 1'b1, "mid_b");
    hv = mk(1, 1, 9, 0, 5, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0); hv.mdu = 1;
    set_in(hv);
    #1;
    chk("mid_pre_busy1", sb_busy1_o, 1'b1);
    chk("mid_pre_stall", sb_stall_o, MDU_EN);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_busy1", sb_busy1_o, 1'b0);
    chk("mid_busy2", sb_busy2_o, 1'b0);
    chk("mid_stall", sb_stall_o, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_cycle(mk(0, 0, 0, 0, 5, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0), 1'b1, "mid_post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

- Register-write scoreboard for the 5-stage RV32 pipeline. It sits beside ID and the forwarding unit, on the producer side of the same register-dependency interface.
- Records every destination register when an instruction issues out of ID and releases it when WB retires the write.
- Tracks results that are not yet forwardable: load data and long-latency MDU results.
- Asserts a stall to ID whenever a source operand cannot be supplied by register file or forwarding.

## Interface
Parameters:
- LOAD_LAT, 1: cycles after load issue before its result is forwardable (legal 1..3)
- CNT_W, 2: width of per-register in-flight writer counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_issue_i  in  1  instruction leaves ID into EX this cycle
- id_reg_we_i  in  1  issuing instruction writes a register
- id_reg_waddr_i  in  5  issuing instruction's rd
- id_is_load_i  in  1  issuing instruction is a load
- id_is_mdu_i  in  1  issuing instruction is a multi-cycle mul/div
- id_reg1_raddr_i, id_reg2_raddr_i  in  5 each  ID source addresses
- cu_reg1_RE_i, cu_reg2_RE_i  in  1 each  source actually read
- wb_reg_we_i  in  1  WB commits a register write this cycle
- wb_reg_waddr_i  in  5  WB destination
- mdu_done_i  in  1  MDU result valid this cycle (forwardable from next cycle)
- flush_i  in  1  full pipeline squash (trap entry); clears all state
- sb_busy1_o, sb_busy2_o  out  1 each  source has an in-flight writer (forwarding required)
- sb_stall_o  out  1  ID must hold; issue not accepted
- sb_err_o  out  1  sticky: WB retired a register with zero count

## Operation
- State per register r=1..31:
  - cnt[r] (CNT_W bits): in-flight writers
  - nr[r]: newest writer not ready
- Register x0 is never tracked. Writes or reads of x0 are ignored, and busy/stall for x0 is always 0.
- Load timer: ld_addr and ld_timer (2 bits).
  - Load issue with we and rd!=0: sets nr[rd], loads ld_timer=LOAD_LAT.
  - Timer decrements each cycle; on reaching 0 it clears nr[ld_addr].
- MDU: mdu_busy and mdu_addr.
  - MDU issue sets nr[rd] and mdu_busy.
  - mdu_done_i clears nr[mdu_addr] and mdu_busy.
- Accepted issue = id_issue_i & ~sb_stall_o. id_issue_i while stalled is ignored (no state change).
- Accepted issue with we: cnt[rd]++. A non-load, non-MDU issue clears nr[rd] (a newer fast writer supersedes the older slow one).
- WB write: cnt[waddr]--.
  - If cnt is already 0: the count stays 0 and sb_err_o is set. sb_err_o clears only on reset.
- Issue and WB to the same register in the same cycle: net count unchanged.
- sb_busyN_o = RE & raddr!=0 & cnt[raddr]!=0.
- sb_stall_o = any of:
  - (a) a read source has nr set
  - (b) issuing with we and cnt[rd] is all-ones, unless WB releases rd this cycle
  - (c) issuing a load while ld_timer!=0
  - (d) issuing an MDU op while mdu_busy and not mdu_done_i
- Outputs are combinational from state and current inputs. There is no combinational path from sb_stall_o back to itself.
- flush_i is synchronous and has priority over everything else. It zeroes cnt, nr, ld_timer and mdu_busy. sb_err_o is unchanged.

## Timing
- Reset values:
  - all cnt and nr 0; ld_timer 0; mdu_busy 0
  - sb_err_o 0
  - sb_busy1_o, sb_busy2_o, sb_stall_o 0 given any inputs
- Issue at edge t: busy and stall visible for the ID occupant in cycle t+1.
- With LOAD_LAT=1, a dependent directly behind a load stalls exactly 1 cycle.
- WB release at edge t: busy drops in cycle t+1.
- MDU: a dependent stalls until the cycle after mdu_done_i.
- Reset asserted mid-operation: all state is cleared immediately (asynchronously). No pending release is replayed.

## Configuration
- SB_MDU_EN defined: MDU tracking (mdu_busy, mdu_addr, stall term d) is present.
- SB_MDU_EN undefined:
  - id_is_mdu_i and mdu_done_i are ignored.
  - MDU ops are tracked as single-cycle writers (cnt only).
  - Stall term d is 0.

## Test plan
- Reset, then issue add x5 (we=1), read x5 next cycle → sb_busy1_o=1, sb_stall_o=0. WB x5 → busy 0 next cycle.
- Issue lw x6, next ID reads x6 (LOAD_LAT=1) → sb_stall_o=1 for exactly 1 cycle, then 0 with sb_busy1_o=1.
- Issue 3 writers to x7 without WB (CNT_W=2), then a 4th → stall. Same cycle with WB x7 → accepted, cnt stays 3.
- SB_MDU_EN: issue div x8, read x8 → stall until mdu_done_i; busy=1, stall=0 the cycle after. A second MDU issue stalls meanwhile.
- WB x9 with cnt[x9]=0 → sb_err_o=1 and stays 1. Accesses to x0 never busy/stall.
- flush_i with x5 busy and x6 nr → next cycle busy 0, no stall. rst_n pulse mid-MDU → mdu_busy 0 immediately.
